// File: rtl/motion_ctrl_mc_pkg.sv
// Shared types for the motion controller: fixed-point/angle typedefs,
// deflection encoding, FSM state encodings and the sample classifier.
package motion_ctrl_mc_pkg;

  localparam int FP_W  = 44;
  localparam int ANG_W = 11;

  typedef logic signed [FP_W-1:0] fp44_t;
  typedef logic [ANG_W-1:0]       angle_t;

  typedef struct packed {
    fp44_t x;
    fp44_t y;
  } pos_xy_t;

  typedef enum logic [1:0] {D_NEG = 2'd0, D_ZERO = 2'd1, D_POS = 2'd2} defl_e;

  typedef enum logic [1:0] {SW_IDLE = 2'd0, SW_CMD = 2'd1, SW_RSP = 2'd2} sweep_state_e;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_SWEEP = 3'd1,
    MC_SIN   = 3'd2,
    MC_COS   = 3'd3,
    MC_APPLY = 3'd4
  } mc_state_e;

  // Samples equal to a threshold are neutral.
  function automatic defl_e classify(input int sample, input int hi_th, input int lo_th);
    if (sample > hi_th) begin
      classify = D_POS;
    end else if (sample < lo_th) begin
      classify = D_NEG;
    end else begin
      classify = D_ZERO;
    end
  endfunction

endpackage

// File: rtl/motion_ctrl_mc_adc_sweeper.sv
// Sweeps NUM_CH ADC channels over the command/response handshake, with a
// per-channel response timeout that substitutes a neutral sample.
module motion_ctrl_mc_adc_sweeper
  import motion_ctrl_mc_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CH_BASE = 1,
  parameter int ADC_W   = 12,
  parameter int TIMEOUT = 4095,
  parameter int NEUTRAL = 1350
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic                         i_cmd_ready,
  input  logic                         i_rsp_valid,
  input  logic [4:0]                   i_rsp_channel,
  input  logic [ADC_W-1:0]             i_rsp_data,
  output logic                         o_cmd_valid,
  output logic [4:0]                   o_cmd_channel,
  output logic [NUM_CH-1:0][ADC_W-1:0] o_samples,
  output logic                         o_sweep_done,
  output logic                         o_sample_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sweep_state_e                  r_state;
  logic [4:0]                    r_idx;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_cmd_valid;
  logic [4:0]                    r_cmd_channel;
  logic [NUM_CH-1:0][ADC_W-1:0]  r_samples;
  logic                          r_done;
  logic                          r_err;

  logic w_rsp_hit;
  logic w_timeout;
  logic w_last;

  assign w_rsp_hit = i_rsp_valid && (i_rsp_channel == (5'(CH_BASE) + r_idx));
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_last    = (r_idx == 5'(NUM_CH - 1));

  // Handshake FSM; a matching response takes priority over an expiring timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SW_IDLE;
      r_idx         <= 5'd0;
      r_cnt         <= {CNT_W{1'b0}};
      r_cmd_valid   <= 1'b0;
      r_cmd_channel <= 5'd0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_samples[k] <= ADC_W'(NEUTRAL);
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SW_IDLE: begin
          if (i_start) begin
            r_idx         <= 5'd0;
            r_cmd_valid   <= 1'b1;
            r_cmd_channel <= 5'(CH_BASE);
            r_state       <= SW_CMD;
          end
        end
        SW_CMD: begin
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_state     <= SW_RSP;
          end
        end
        SW_RSP: begin
          if (w_rsp_hit || w_timeout) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (5'(k) == r_idx) begin
                r_samples[k] <= w_rsp_hit ? i_rsp_data : ADC_W'(NEUTRAL);
              end
            end
            if (!w_rsp_hit) begin
              r_err <= 1'b1;
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= SW_IDLE;
            end else begin
              r_idx         <= r_idx + 5'd1;
              r_cmd_valid   <= 1'b1;
              r_cmd_channel <= 5'(CH_BASE) + r_idx + 5'd1;
              r_state       <= SW_CMD;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= SW_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_channel = r_cmd_channel;
  assign o_samples     = r_samples;
  assign o_sweep_done  = r_done;
  assign o_sample_err  = r_err;

endmodule

// File: rtl/motion_ctrl_mc.sv
// Per-frame player motion integrator: joystick sweep, sin/cos fetch from the
// shared trig LUT, then a single-cycle position/heading/horizon update.
module motion_ctrl_mc
  import motion_ctrl_mc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CH_BASE    = 1,
  parameter int ADC_W      = 12,
  parameter int HI_TH      = 2000,
  parameter int LO_TH      = 700,
  parameter int ANGLE_W    = 11,
  parameter int POS_W      = 44,
  parameter int ANGLE_RST  = 512,
  parameter int TURN_SPEED = 5,
  parameter int MOVE_SHIFT = 2,
  parameter int TRIG_LAT   = 1,
  parameter int TIMEOUT    = 4095,
  parameter int HOR_RST    = 80,
  parameter int HOR_MIN    = 0,
  parameter int HOR_MAX    = 159
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               half_frame,
  output logic               adc_cmd_valid,
  output logic [4:0]         adc_cmd_channel,
  input  logic               adc_cmd_ready,
  input  logic               adc_rsp_valid,
  input  logic [4:0]         adc_rsp_channel,
  input  logic [ADC_W-1:0]   adc_rsp_data,
  output logic [ANGLE_W-1:0] trig_angle,
  input  logic [POS_W-1:0]   trig_val,
  input  logic               look_up_n,
  input  logic               look_down_n,
  output logic [ANGLE_W-1:0] angle_out,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic [16:0]        horizon,
  output logic               busy,
  output logic               frame_done,
  output logic               sample_err
);

  // Neutral sits between the thresholds so a substituted sample never moves the player.
  localparam int NEUTRAL = (HI_TH + LO_TH) / 2;
  localparam logic [ANGLE_W-1:0] QUARTER = ANGLE_W'(1 << (ANGLE_W - 2));

  mc_state_e                    r_state;
  logic                         r_half_q;
  logic [3:0]                   r_wait;
  logic [ANGLE_W-1:0]           r_trig_angle;
  logic [POS_W-1:0]             r_sin;
  logic [POS_W-1:0]             r_cos;
  logic [ANGLE_W-1:0]           r_angle;
  logic [POS_W-1:0]             r_pos_x;
  logic [POS_W-1:0]             r_pos_y;
  logic [16:0]                  r_hor;
  logic                         r_busy;
  logic                         r_done;

  logic                         w_new_frame;
  logic                         w_start;
  logic                         w_sweep_done;
  logic [NUM_CH-1:0][ADC_W-1:0] w_samples;
  defl_e                        w_d0;
  defl_e                        w_d1;
  defl_e                        w_d2;
  logic [POS_W-1:0]             w_ds;
  logic [POS_W-1:0]             w_dc;
  logic [ANGLE_W-1:0]           w_turn;
  logic [POS_W-1:0]             w_next_x;
  logic [POS_W-1:0]             w_next_y;
  logic [16:0]                  w_next_hor;

  function automatic logic [POS_W-1:0] scale(input defl_e d, input logic [POS_W-1:0] v);
    case (d)
      D_POS:   scale = v;
      D_NEG:   scale = {POS_W{1'b0}} - v;
      default: scale = {POS_W{1'b0}};
    endcase
  endfunction

  assign w_new_frame = half_frame & ~r_half_q;
  assign w_start     = w_new_frame && (r_state == MC_IDLE);

  motion_ctrl_mc_adc_sweeper #(
    .NUM_CH  (NUM_CH),
    .CH_BASE (CH_BASE),
    .ADC_W   (ADC_W),
    .TIMEOUT (TIMEOUT),
    .NEUTRAL (NEUTRAL)
  ) u_sweeper (
    .clk           (clk),
    .reset         (reset),
    .i_start       (w_start),
    .i_cmd_ready   (adc_cmd_ready),
    .i_rsp_valid   (adc_rsp_valid),
    .i_rsp_channel (adc_rsp_channel),
    .i_rsp_data    (adc_rsp_data),
    .o_cmd_valid   (adc_cmd_valid),
    .o_cmd_channel (adc_cmd_channel),
    .o_samples     (w_samples),
    .o_sweep_done  (w_sweep_done),
    .o_sample_err  (sample_err)
  );

  assign w_d0 = classify(int'(w_samples[0]), HI_TH, LO_TH);
  assign w_d1 = classify(int'(w_samples[1]), HI_TH, LO_TH);

  generate
    if (NUM_CH > 2) begin : g_strafe
      assign w_d2 = classify(int'(w_samples[2]), HI_TH, LO_TH);
    end else begin : g_no_strafe
      assign w_d2 = D_ZERO;
    end
  endgenerate

  // Next-state arithmetic for the APPLY cycle; all position math wraps.
  always_comb begin
    w_ds     = POS_W'($signed(r_sin) >>> MOVE_SHIFT);
    w_dc     = POS_W'($signed(r_cos) >>> MOVE_SHIFT);
    w_next_x = r_pos_x + scale(w_d0, w_dc) + scale(w_d2, w_ds);
    w_next_y = r_pos_y + scale(w_d0, w_ds) - scale(w_d2, w_dc);
    case (w_d1)
      D_POS:   w_turn = ANGLE_W'(TURN_SPEED);
      D_NEG:   w_turn = {ANGLE_W{1'b0}} - ANGLE_W'(TURN_SPEED);
      default: w_turn = {ANGLE_W{1'b0}};
    endcase
    if (!look_up_n && (r_hor > 17'(HOR_MIN))) begin
      w_next_hor = r_hor - 17'd1;
    end else if (!look_down_n && (r_hor < 17'(HOR_MAX))) begin
      w_next_hor = r_hor + 17'd1;
    end else begin
      w_next_hor = r_hor;
    end
  end

  // Frame sequencer: sweep, sin fetch, cos fetch, single-cycle commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= MC_IDLE;
      r_half_q     <= 1'b0;
      r_wait       <= 4'd0;
      r_trig_angle <= {ANGLE_W{1'b0}};
      r_sin        <= {POS_W{1'b0}};
      r_cos        <= {POS_W{1'b0}};
      r_angle      <= ANGLE_W'(ANGLE_RST);
      r_pos_x      <= {POS_W{1'b0}};
      r_pos_y      <= {POS_W{1'b0}};
      r_hor        <= 17'(HOR_RST);
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_half_q <= half_frame;
      r_done   <= 1'b0;
      case (r_state)
        MC_IDLE: begin
          if (w_new_frame) begin
            r_busy  <= 1'b1;
            r_state <= MC_SWEEP;
          end
        end
        MC_SWEEP: begin
          if (w_sweep_done) begin
            r_trig_angle <= r_angle;
            r_wait       <= 4'd0;
            r_state      <= MC_SIN;
          end
        end
        MC_SIN: begin
          if (r_wait == 4'(TRIG_LAT)) begin
            r_sin        <= trig_val;
            r_trig_angle <= r_angle + QUARTER;
            r_wait       <= 4'd0;
            r_state      <= MC_COS;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        MC_COS: begin
          if (r_wait == 4'(TRIG_LAT)) begin
            r_cos   <= trig_val;
            r_wait  <= 4'd0;
            r_state <= MC_APPLY;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        MC_APPLY: begin
          r_pos_x <= w_next_x;
          r_pos_y <= w_next_y;
          r_angle <= r_angle + w_turn;
          r_hor   <= w_next_hor;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= MC_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= MC_IDLE;
        end
      endcase
    end
  end

  assign trig_angle = r_trig_angle;
  assign angle_out  = r_angle;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign horizon    = r_hor;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: doc/motion_ctrl_mc.md
Name: motion_ctrl_mc

Overview:
Per-frame player motion integrator with a parametrised multi-channel joystick front end. Once per frame it sweeps NUM_CH ADC channels over a command/response handshake, with a timeout on each channel. It then fetches sin and cos of the current heading from the shared trig LUT and applies forward/back, turn, optional strafe and horizon look updates in a single cycle. It sits between the ADC Qsys core and the renderer, and supplies angle, position and horizon.

Parameters:
NUM_CH, 2, joystick channels swept per frame (2 or 3); ch0=fwd/back, ch1=turn, ch2=strafe
CH_BASE, 1, ADC channel number of ch0; channel k is CH_BASE+k
ADC_W, 12, ADC sample width
HI_TH, 2000, sample > HI_TH means +1 deflection
LO_TH, 700, sample < LO_TH means -1 deflection
ANGLE_W, 11, heading width; full circle is 2^ANGLE_W
POS_W, 44, position and trig-value width (fp44)
ANGLE_RST, 512, heading after reset
TURN_SPEED, 5, heading step per frame
MOVE_SHIFT, 2, arithmetic right shift applied to sin/cos per step
TRIG_LAT, 1, trig LUT latency in cycles
TIMEOUT, 4095, max cycles to wait for a response per channel
HOR_RST, 80, horizon after reset
HOR_MIN, 0, horizon lower clamp
HOR_MAX, 159, horizon upper clamp

Ports:
clk  in  1  system clock (ADC sys_clk domain)
reset  in  1  asynchronous, active-high
half_frame  in  1  high for roughly the first half of each frame
adc_cmd_valid  out  1  ADC command valid
adc_cmd_channel  out  5  ADC channel requested
adc_cmd_ready  in  1  ADC command accepted
adc_rsp_valid  in  1  ADC response valid
adc_rsp_channel  in  5  response channel
adc_rsp_data  in  ADC_W  response sample
trig_angle  out  ANGLE_W  LUT address
trig_val  in  POS_W  LUT sine output, signed
look_up_n  in  1  active-low button
look_down_n  in  1  active-low button
angle_out  out  ANGLE_W  heading
pos_x  out  POS_W  signed x position
pos_y  out  POS_W  signed y position
horizon  out  17  horizon row
busy  out  1  high while an update is in progress
frame_done  out  1  one-cycle pulse when the update is committed
sample_err  out  1  sticky flag: a channel timed out; cleared only by reset

Behaviour:
- Reset (async) values: angle_out=ANGLE_RST, pos_x=pos_y=0, horizon=HOR_RST, adc_cmd_valid=0, busy=0, frame_done=0, sample_err=0, state=IDLE, all sample registers at midscale (neutral).
- new_frame = half_frame & ~half_frame_q, using a registered previous value. It is acted on only in IDLE; while busy it is dropped.
- State IDLE:
  - on new_frame: idx=0, busy=1, go to CMD.
- State CMD:
  - adc_cmd_valid=1, adc_cmd_channel=CH_BASE+idx.
  - when adc_cmd_ready=1: drop valid next cycle, clear the timeout counter, go to RSP.
- State RSP:
  - on adc_rsp_valid with adc_rsp_channel==CH_BASE+idx: store sample[idx].
  - responses on any other channel are ignored.
  - if TIMEOUT cycles pass with no match: store neutral for sample[idx] and set sample_err.
  - then idx++; go to CMD if idx<NUM_CH, else SIN.
- State SIN:
  - trig_angle=angle_out; wait TRIG_LAT cycles, then latch sin=trig_val.
- State COS:
  - trig_angle=angle_out+2^(ANGLE_W-2), modulo 2^ANGLE_W; wait TRIG_LAT cycles, then latch cos.
- State APPLY (one cycle), then IDLE with frame_done=1 and busy=0:
  - Deflection per channel: d=+1 if sample>HI_TH, -1 if sample<LO_TH, else 0. Values equal to a threshold give 0.
  - ds = sin>>>MOVE_SHIFT, dc = cos>>>MOVE_SHIFT (sign-extended).
  - pos_x += d0*dc + d2*ds.
  - pos_y += d0*ds − d2*dc.
  - d2 is forced to 0 when NUM_CH=2.
  - Position arithmetic is POS_W two's complement and wraps; there is no saturation.
  - angle_out += d1*TURN_SPEED, modulo 2^ANGLE_W; wraps both ways.
  - Horizon:
    - if look_up_n=0 and horizon>HOR_MIN: horizon−1.
    - else if look_down_n=0 and horizon<HOR_MAX: horizon+1.
    - If both buttons are pressed, up wins.
- All outputs are registered. Frame update latency is at most NUM_CH*(TIMEOUT+handshake)+2*(TRIG_LAT+1)+1 cycles.
- A reset mid-sweep aborts immediately. Pending ADC responses after reset are ignored until the next CMD.

Decomposition:
- Shared package (structs.sv):
  - fp44 and angle typedefs.
  - posXY struct; pos_x/pos_y may be bundled as posXY at top level.
  - Deflection encoding enum {NEG, ZERO, POS}.
- Sub-module adc_sweeper: the CMD/RSP/timeout FSM. It produces the sample array and a sweep-done pulse.
- The integrator and trig sequencing stay in the top module.

Test Plan:
- Reset, angle=512, LUT model gives sin=4096 and cos=0, ch0 response 3000, ch1 response 1500, one frame → pos_y=1024, pos_x=0, angle_out=512, frame_done pulses once.
- Ch1 response 100 with angle_out=2 → angle_out=2045 (wrap); ch1 response 4000 with angle_out=2046 → angle_out=3.
- NUM_CH=3, angle=0, LUT sin=0 and cos=4096, ch0 neutral, ch2 response 3000 → pos_y=−1024, pos_x=0.
- ADC never responds on ch0 → after TIMEOUT cycles sample_err=1, ch0 treated as neutral, sweep continues to ch1, position unchanged.
- Wrong-channel response, then the correct one, ch0 sample exactly 2000 → wrong one ignored, d0=0, no movement.
- Horizon at HOR_MIN with look_up_n=0 → stays 0; both buttons pressed at 80 → 79; new_frame during busy → no second update; reset asserted mid-RSP → outputs return to reset values asynchronously.
